pwm_multi: RTL

- Multi-channel PWM generator, the parametrised successor of the single-channel pwm.
- CH channels share one period counter. Each channel has its own duty register.
- Duty and period writes are double-buffered and take effect only at a period boundary, so mid-period updates cannot glitch the output.
- Supports edge-aligned and center-aligned modes. Drives motor/servo outputs on the PYNQ car platform.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/pwm_deadtime.sv | 51 +++++
 rtl/pwm_multi.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM: counter mode, count direction and
// channel-index width helper.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    // A single-channel build still needs a one-bit write index.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output pair with delayed rising edges for one PWM channel.
// Only instantiated when PWM_DEADTIME_EN is defined.
module pwm_deadtime #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    output logic            pwm_out,
    output logic            pwm_out_n
);

    logic            level_q, level_d;
    logic [DT_W-1:0] run_q, run_d;
    logic            p_q, p_d;
    logic            n_q, n_d;

    // run counts how long the raw level has been stable; an output only rises
    // once that reaches dead_time, so short pulses never appear at all.
    always_comb begin
        level_d = pwm_in;
        run_d   = run_q;
        if (!en || (pwm_in != level_q)) begin
            run_d = '0;
        end else if (run_q != '1) begin
            run_d = run_q + 1'b1;
        end
        p_d = en &&  pwm_in && (run_d >= dead_time);
        n_d = en && !pwm_in && (run_d >= dead_time);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            run_q   <= '0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            level_q <= level_d;
            run_q   <= run_d;
            p_q     <= p_d;
            n_q     <= n_d;
        end
    end

    assign pwm_out   = p_q;
    assign pwm_out_n = n_q;

endmodule

// File: rtl/pwm_multi.sv
// CH-channel PWM sharing one edge/center-aligned counter, with duty/period
// double-buffered to the period boundary. Define PWM_DEADTIME_EN for outputs with dead time.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH   = 4,
    parameter int W    = 32,
    parameter int DT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [W-1:0]              period,
    input  logic                      center,
    input  logic                      wr_en,
    input  logic [ch_idx_w(CH)-1:0]   wr_ch,
    input  logic [W-1:0]              wr_duty,
`ifdef PWM_DEADTIME_EN
    input  logic [DT_W-1:0]           dead_time,
    output logic [CH-1:0]             pwm_out_n,
`endif
    output logic [CH-1:0]             pwm_out,
    output logic                      period_tick,
    output logic [W-1:0]              cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_act_q, period_act_d;
    dir_e         dir_q, dir_d;
    mode_e        mode_q, mode_d;
    logic [W-1:0] shadow_q   [CH];
    logic [W-1:0] shadow_d   [CH];
    logic [W-1:0] duty_act_q [CH];
    logic [W-1:0] duty_act_d [CH];
    logic         tick_q, tick_d;
    logic         boundary;
    logic         load;
    logic [CH-1:0] cmp;

    // Boundary is whenever the next count is the first 0 of a new period.
    always_comb begin
        cnt_d    = '0;
        dir_d    = UP;
        boundary = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (period_act_q == '0) begin
            boundary = 1'b1;
        end else if (mode_q == PWM_EDGE) begin
            if (cnt_q >= period_act_q) begin
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if ((dir_q == UP) && (cnt_q < period_act_q)) begin
                cnt_d = cnt_q + 1'b1;
            end else if (cnt_q == '0) begin
                cnt_d = W'(1);
            end else begin
                cnt_d    = cnt_q - 1'b1;
                dir_d    = (cnt_q == W'(1)) ? UP : DOWN;
                boundary = (cnt_q == W'(1));
            end
        end
    end

    assign load = !en || boundary;

    always_comb begin
        shadow_d     = shadow_q;
        duty_act_d   = duty_act_q;
        period_act_d = period_act_q;
        mode_d       = mode_q;
        for (int i = 0; i < CH; i++) begin
            if (wr_en && (int'(wr_ch) == i)) begin
                shadow_d[i] = wr_duty;
            end
        end
        // Active side takes the pre-edge shadow, so a coincident write waits a period.
        if (load) begin
            duty_act_d   = shadow_q;
            period_act_d = period;
            mode_d       = center ? PWM_CENTER : PWM_EDGE;
        end
        tick_d = en && boundary;
        for (int i = 0; i < CH; i++) begin
            cmp[i] = en && (duty_act_q[i] > cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            dir_q        <= UP;
            period_act_q <= '0;
            mode_q       <= PWM_EDGE;
            shadow_q     <= '{default: '0};
            duty_act_q   <= '{default: '0};
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            period_act_q <= period_act_d;
            mode_q       <= mode_d;
            shadow_q     <= shadow_d;
            duty_act_q   <= duty_act_d;
            tick_q       <= tick_d;
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DT_W-1:0] dt_act_q, dt_act_d;

    always_comb begin
        dt_act_d = load ? dead_time : dt_act_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dt_act_q <= '0;
        end else begin
            dt_act_q <= dt_act_d;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_dt
        pwm_deadtime #(.DT_W(DT_W)) u_dt (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .pwm_in    (cmp[g]),
            .dead_time (dt_act_q),
            .pwm_out   (pwm_out[g]),
            .pwm_out_n (pwm_out_n[g])
        );
    end
`else
    logic [CH-1:0] pwm_q, pwm_d;

    always_comb begin
        pwm_d = cmp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
`endif

    assign period_tick = tick_q;
    assign cnt_o       = cnt_q;

endmodule
